decode_regfiles: RTL and testbench
==================================

Name: decode_regfiles

Overview:
- Combined register-file block for the decode stage of the Dioptase pipeline.
- Holds the 32×32 general-purpose register file: two synchronous read ports, two write ports, and a dedicated return-value tap.
- Holds the control-register file: one synchronous read port, one write port, hardware exception capture, interrupt latching and masking, and kernel-mode status.
- Read ports feed the decode→execute pipeline register. Write ports are driven from writeback.

Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_1  in  5  GPR read address A.
- d_1  out  32  GPR read data A.
- s_2  in  5  GPR read address B.
- d_2  out  32  GPR read data B.
- we1  in  1  GPR write enable, port 1.
- target_1  in  5  GPR write address, port 1.
- write_data_1  in  32  GPR write data, port 1.
- we2  in  1  GPR write enable, port 2.
- target_2  in  5  GPR write address, port 2.
- write_data_2  in  32  GPR write data, port 2.
- stall  in  1  hold all read outputs.
- ret_val  out  32  combinational copy of r1.
- cs  in  5  control-register read address.
- cd  out  32  control-register read data.
- cwe  in  1  control-register write enable.
- ctgt  in  5  control-register write address.
- cwrite_data  in  32  control-register write data.
- exc_in_wb  in  1  exception retiring in writeback.
- tlb_exc_in_wb  in  1  TLB exception retiring in writeback.
- tlb_addr  in  32  faulting address.
- epc  in  32  exception PC.
- efg  in  32  exception flags.
- interrupts  in  16  interrupt request lines, level-sampled each cycle.
- kmode  out  1  CR0 bit 0 (kernel mode).
- cdv  out  32  CR6 contents.
- interrupt_state  out  32  pending and enabled interrupts.

Behaviour:
GPR file:
- r0 reads 0 and ignores writes.
- Reads are registered. When stall=0, on each edge d_1 <= r[s_1] and d_2 <= r[s_2]. When stall=1, d_1 and d_2 hold.
- Write-first bypass: if a read address equals an enabled, nonzero write target in the same cycle, the read captures that write's data.
- Same target on both write ports: port 1 wins, for both storage and bypass.
- Writes happen regardless of stall.
- Reset: all registers = 0, d_1 = 0, d_2 = 0.

Control registers (address map):
- CR0 PSR: bit 0 = kmode.
- CR1 PID.
- CR2 ISR: pending interrupts, bits 15:0.
- CR3 IMR: bits 15:0 = enables, bit 31 = global enable.
- CR4 EPC.
- CR5 EFG.
- CR6 CDV.
- CR7 TLB (faulting address).
- CR8–CR15: scratch.
- CR16–CR31: read 0, writes ignored.
- Unused bits of CR0 and CR2 read 0.

Control-register read and write:
- cd is registered like the GPR reads: it updates only when stall=0, with the same write-first bypass against cwe/ctgt.
- Write priority, per cycle: exception capture > ISR latch/clear > cwe write.

Exception capture:
- exc_in_wb=1: EPC <= epc, EFG <= efg, PSR.kmode <= 1.
- tlb_exc_in_wb=1: additionally TLB <= tlb_addr.
- tlb_exc_in_wb without exc_in_wb updates TLB only.

ISR update:
- Each cycle: ISR <= (cwe && ctgt==2 ? cwrite_data[15:0] : ISR) | interrupts.
- A newly raised line wins over a software clear in the same cycle.

Interrupt output:
- interrupt_state = IMR[31] ? {16'b0, ISR[15:0] & IMR[15:0]} : 0.
- Purely combinational from current state.

Other outputs:
- kmode and cdv are combinational from current state.

Reset:
- All CRs = 0 except PSR.kmode = 1.
- cd = 0.

Test Plan:
- Reset, then read r0–r31 and CR0–CR15 with stall=0. Required: all d_1, d_2, cd = 0 except cd = 1 for CR0; kmode = 1; interrupt_state = 0.
- we1, target_1=5, data 0xDEADBEEF; same cycle s_1=5. Required: d_1 = 0xDEADBEEF after the edge (bypass). Then write r0 = 7 and read r0: required 0. Write r1 = 0x42: required ret_val = 0x42.
- we1 and we2 both target 9, data 0x11 and 0x22. Required: r9 = 0x11. Hold stall=1 while changing s_2: required d_2 held.
- Pulse exc_in_wb + tlb_exc_in_wb with epc=0x100, efg=0x3, tlb_addr=0xABC, while cwe writes CR4 = 0x999. Required: CR4 = 0x100, CR5 = 3, CR7 = 0xABC, kmode = 1.
- Write CR3 = 0x8000_0005, pulse interrupts = 0x0004. Required: ISR = 4, interrupt_state = 4. Then write CR2 = 0 with interrupts = 0: required interrupt_state = 0. Then write CR3 = 0x0000_0005 and raise line 0: required interrupt_state = 0 (global enable clear).
- Write CR0 = 0 and CR6 = 0x1234. Required: kmode = 0, cdv = 0x1234. Write CR20: required reads 0.

Source files
------------

// File: rtl/decode_regfiles.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_regfiles: decode-stage GPR file (2R/2W) and control-register file |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module decode_regfiles (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  s_1,
  output logic [31:0] d_1,
  input  logic [4:0]  s_2,
  output logic [31:0] d_2,
  input  logic        we1,
  input  logic [4:0]  target_1,
  input  logic [31:0] write_data_1,
  input  logic        we2,
  input  logic [4:0]  target_2,
  input  logic [31:0] write_data_2,
  input  logic        stall,
  output logic [31:0] ret_val,
  input  logic [4:0]  cs,
  output logic [31:0] cd,
  input  logic        cwe,
  input  logic [4:0]  ctgt,
  input  logic [31:0] cwrite_data,
  input  logic        exc_in_wb,
  input  logic        tlb_exc_in_wb,
  input  logic [31:0] tlb_addr,
  input  logic [31:0] epc,
  input  logic [31:0] efg,
  input  logic [15:0] interrupts,
  output logic        kmode,
  output logic [31:0] cdv,
  output logic [31:0] interrupt_state
);

  localparam int unsigned CR_PSR = 0;
  localparam int unsigned CR_ISR = 2;
  localparam int unsigned CR_IMR = 3;
  localparam int unsigned CR_EPC = 4;
  localparam int unsigned CR_EFG = 5;
  localparam int unsigned CR_CDV = 6;
  localparam int unsigned CR_TLB = 7;

  logic [31:0] gpr_q [32];
  logic [31:0] gpr_d [32];
  logic [31:0] cr_q  [16];
  logic [31:0] cr_d  [16];
  logic [31:0] d_1_q, d_1_d;
  logic [31:0] d_2_q, d_2_d;
  logic [31:0] cd_q,  cd_d;
  logic        isr_sw_write;

  // Reads sample the next-state array, which gives write-first bypass for free.
  always_comb begin
    gpr_d = gpr_q;
    if (we2 && (target_2 != 5'd0)) gpr_d[target_2] = write_data_2;
    if (we1 && (target_1 != 5'd0)) gpr_d[target_1] = write_data_1;
    d_1_d = stall ? d_1_q : gpr_d[s_1];
    d_2_d = stall ? d_2_q : gpr_d[s_2];
  end

  // Layered lowest priority first: software write, ISR latch, exception capture.
  always_comb begin
    cr_d = cr_q;
    isr_sw_write = cwe && (ctgt == 5'd2);
    if (cwe && !ctgt[4] && (ctgt != 5'd2)) cr_d[ctgt[3:0]] = cwrite_data;
    cr_d[CR_ISR] = {16'b0, (isr_sw_write ? cwrite_data[15:0] : cr_q[CR_ISR][15:0]) | interrupts};
    if (exc_in_wb) begin
      cr_d[CR_EPC]    = epc;
      cr_d[CR_EFG]    = efg;
      cr_d[CR_PSR][0] = 1'b1;
    end
    if (tlb_exc_in_wb) cr_d[CR_TLB] = tlb_addr;
    cr_d[CR_PSR] = {31'b0, cr_d[CR_PSR][0]};
    if (stall)       cd_d = cd_q;
    else if (cs[4])  cd_d = 32'd0;
    else             cd_d = cr_d[cs[3:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
      for (int i = 0; i < 16; i++) cr_q[i]  <= 32'd0;
      cr_q[CR_PSR] <= 32'd1;
      d_1_q <= 32'd0;
      d_2_q <= 32'd0;
      cd_q  <= 32'd0;
    end else begin
      gpr_q <= gpr_d;
      cr_q  <= cr_d;
      d_1_q <= d_1_d;
      d_2_q <= d_2_d;
      cd_q  <= cd_d;
    end
  end

  assign d_1             = d_1_q;
  assign d_2             = d_2_q;
  assign cd              = cd_q;
  assign ret_val         = gpr_q[1];
  assign kmode           = cr_q[CR_PSR][0];
  assign cdv             = cr_q[CR_CDV];
  assign interrupt_state = cr_q[CR_IMR][31] ?
                           {16'b0, cr_q[CR_ISR][15:0] & cr_q[CR_IMR][15:0]} : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_decode_regfiles.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_regfiles: directed self-checking bench for decode_regfiles     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_decode_regfiles;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  s_1, s_2, target_1, target_2, cs, ctgt;
  logic [31:0] d_1, d_2, write_data_1, write_data_2, ret_val, cd, cwrite_data;
  logic        we1, we2, stall, cwe, exc_in_wb, tlb_exc_in_wb, kmode;
  logic [31:0] tlb_addr, epc, efg, cdv, interrupt_state;
  logic [15:0] interrupts;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decode_regfiles dut (
    .clk(clk), .rst(rst),
    .s_1(s_1), .d_1(d_1), .s_2(s_2), .d_2(d_2),
    .we1(we1), .target_1(target_1), .write_data_1(write_data_1),
    .we2(we2), .target_2(target_2), .write_data_2(write_data_2),
    .stall(stall), .ret_val(ret_val),
    .cs(cs), .cd(cd), .cwe(cwe), .ctgt(ctgt), .cwrite_data(cwrite_data),
    .exc_in_wb(exc_in_wb), .tlb_exc_in_wb(tlb_exc_in_wb), .tlb_addr(tlb_addr),
    .epc(epc), .efg(efg), .interrupts(interrupts),
    .kmode(kmode), .cdv(cdv), .interrupt_state(interrupt_state)
  );

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we1 = 0; we2 = 0; cwe = 0; exc_in_wb = 0; tlb_exc_in_wb = 0; stall = 0;
    target_1 = 0; target_2 = 0; write_data_1 = 0; write_data_2 = 0;
    ctgt = 0; cwrite_data = 0; interrupts = 0; tlb_addr = 0; epc = 0; efg = 0;
  endtask

  task automatic cr_write(input logic [4:0] a, input logic [31:0] v);
    cwe = 1; ctgt = a; cwrite_data = v;
    tick();
    cwe = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); s_1 = 0; s_2 = 0; cs = 0; rst = 1;
    tick(); tick();
    tests_run++;
    if (d_1 !== 32'd0 || d_2 !== 32'd0 || cd !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: d_1=%h d_2=%h cd=%h, required all 0", d_1, d_2, cd);
    end
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      s_1 = 5'(i); s_2 = 5'(31 - i);
      tick();
      tests_run++;
      if (d_1 !== 32'd0 || d_2 !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_gpr[%0d]: d_1=%h d_2=%h, required 0", i, d_1, d_2);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cs = 5'(i);
      tick();
      tests_run++;
      if (cd !== ((i == 0) ? 32'd1 : 32'd0)) begin
        tests_failed++;
        $display("FAIL reset_cr[%0d]: cd=%h, required %h", i, cd, (i == 0) ? 32'd1 : 32'd0);
      end
    end
    tests_run++;
    if (kmode !== 1'b1 || interrupt_state !== 32'd0 || ret_val !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_status: kmode=%b intr=%h ret=%h, required 1/0/0", kmode, interrupt_state, ret_val);
    end
  endtask

  task automatic test_bypass();
    we1 = 1; target_1 = 5; write_data_1 = 32'hDEADBEEF; s_1 = 5;
    tick();
    we1 = 0;
    tests_run++;
    if (d_1 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL bypass_r5: d_1=%h, required deadbeef", d_1);
    end
    s_2 = 5;
    tick();
    tests_run++;
    if (d_2 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL stored_r5: d_2=%h, required deadbeef", d_2);
    end
    we1 = 1; target_1 = 0; write_data_1 = 32'd7; s_1 = 0;
    tick();
    we1 = 0;
    tests_run++;
    if (d_1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL r0_bypass: d_1=%h, required 0", d_1);
    end
    tick();
    tests_run++;
    if (d_1 !== 32'd0) begin
      tests_failed++;
      $display("FAIL r0_stored: d_1=%h, required 0", d_1);
    end
    we1 = 1; target_1 = 1; write_data_1 = 32'h42;
    tick();
    we1 = 0;
    tests_run++;
    if (ret_val !== 32'h42) begin
      tests_failed++;
      $display("FAIL ret_val: ret_val=%h, required 42", ret_val);
    end
  endtask

  task automatic test_dual_write();
    we1 = 1; target_1 = 9; write_data_1 = 32'h11;
    we2 = 1; target_2 = 9; write_data_2 = 32'h22;
    s_2 = 9;
    tick();
    we1 = 0; we2 = 0;
    tests_run++;
    if (d_2 !== 32'h11) begin
      tests_failed++;
      $display("FAIL dual_bypass: d_2=%h, required 11", d_2);
    end
    s_1 = 9;
    tick();
    tests_run++;
    if (d_1 !== 32'h11) begin
      tests_failed++;
      $display("FAIL dual_stored: d_1=%h, required 11", d_1);
    end
    we2 = 1; target_2 = 10; write_data_2 = 32'h33; s_1 = 10;
    tick();
    we2 = 0;
    tests_run++;
    if (d_1 !== 32'h33) begin
      tests_failed++;
      $display("FAIL port2_bypass: d_1=%h, required 33", d_1);
    end
    // stalled: outputs hold while a write still lands
    stall = 1; s_1 = 5; s_2 = 5;
    we1 = 1; target_1 = 12; write_data_1 = 32'h55;
    tick();
    we1 = 0;
    tick();
    tests_run++;
    if (d_1 !== 32'h33 || d_2 !== 32'h11) begin
      tests_failed++;
      $display("FAIL stall_hold: d_1=%h d_2=%h, required 33/11", d_1, d_2);
    end
    stall = 0; s_1 = 12;
    tick();
    tests_run++;
    if (d_1 !== 32'h55 || d_2 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL write_during_stall: d_1=%h d_2=%h, required 55/deadbeef", d_1, d_2);
    end
  endtask

  task automatic test_exception();
    cr_write(5'd0, 32'd0);
    tests_run++;
    if (kmode !== 1'b0) begin
      tests_failed++;
      $display("FAIL kmode_clear: kmode=%b, required 0", kmode);
    end
    cwe = 1; ctgt = 4; cwrite_data = 32'h999;
    exc_in_wb = 1; tlb_exc_in_wb = 1; epc = 32'h100; efg = 32'h3; tlb_addr = 32'hABC;
    tick();
    cwe = 0; exc_in_wb = 0; tlb_exc_in_wb = 0;
    tests_run++;
    if (kmode !== 1'b1) begin
      tests_failed++;
      $display("FAIL exc_kmode: kmode=%b, required 1", kmode);
    end
    cs = 4; tick();
    tests_run++;
    if (cd !== 32'h100) begin
      tests_failed++;
      $display("FAIL exc_epc: cd=%h, required 100", cd);
    end
    cs = 5; tick();
    tests_run++;
    if (cd !== 32'h3) begin
      tests_failed++;
      $display("FAIL exc_efg: cd=%h, required 3", cd);
    end
    cs = 7; tick();
    tests_run++;
    if (cd !== 32'hABC) begin
      tests_failed++;
      $display("FAIL exc_tlb: cd=%h, required abc", cd);
    end
    cr_write(5'd0, 32'd0);
    tlb_exc_in_wb = 1; tlb_addr = 32'h55; epc = 32'h777; efg = 32'h9;
    tick();
    tlb_exc_in_wb = 0;
    cs = 7; tick();
    tests_run++;
    if (cd !== 32'h55) begin
      tests_failed++;
      $display("FAIL tlb_only_tlb: cd=%h, required 55", cd);
    end
    cs = 4; tick();
    tests_run++;
    if (cd !== 32'h100 || kmode !== 1'b0) begin
      tests_failed++;
      $display("FAIL tlb_only_epc: cd=%h kmode=%b, required 100/0", cd, kmode);
    end
  endtask

  task automatic test_interrupts();
    cr_write(5'd3, 32'h8000_0005);
    interrupts = 16'h0004;
    tick();
    interrupts = 16'h0000;
    tests_run++;
    if (interrupt_state !== 32'd4) begin
      tests_failed++;
      $display("FAIL intr_pending: intr=%h, required 4", interrupt_state);
    end
    cs = 2; tick();
    tests_run++;
    if (cd !== 32'd4) begin
      tests_failed++;
      $display("FAIL isr_read: cd=%h, required 4", cd);
    end
    cr_write(5'd2, 32'd0);
    tests_run++;
    if (interrupt_state !== 32'd0) begin
      tests_failed++;
      $display("FAIL intr_clear: intr=%h, required 0", interrupt_state);
    end
    // a line raised during a software clear must survive it
    interrupts = 16'h0001;
    cr_write(5'd2, 32'd0);
    interrupts = 16'h0000;
    tests_run++;
    if (interrupt_state !== 32'd1) begin
      tests_failed++;
      $display("FAIL raise_beats_clear: intr=%h, required 1", interrupt_state);
    end
    cr_write(5'd2, 32'd0);
    interrupts = 16'h0002;
    tick();
    interrupts = 16'h0000;
    tests_run++;
    if (interrupt_state !== 32'd0) begin
      tests_failed++;
      $display("FAIL intr_masked_line: intr=%h, required 0", interrupt_state);
    end
    cr_write(5'd2, 32'd0);
    cr_write(5'd3, 32'h0000_0005);
    interrupts = 16'h0001;
    tick();
    interrupts = 16'h0000;
    cs = 2; tick();
    tests_run++;
    if (interrupt_state !== 32'd0 || cd !== 32'd1) begin
      tests_failed++;
      $display("FAIL global_disable: intr=%h isr=%h, required 0/1", interrupt_state, cd);
    end
  endtask

  task automatic test_cr_misc();
    cr_write(5'd0, 32'hFFFF_FFFF);
    cs = 0; tick();
    tests_run++;
    if (cd !== 32'd1 || kmode !== 1'b1) begin
      tests_failed++;
      $display("FAIL psr_mask: cd=%h kmode=%b, required 1/1", cd, kmode);
    end
    cr_write(5'd0, 32'd0);
    cr_write(5'd6, 32'h1234);
    tests_run++;
    if (kmode !== 1'b0 || cdv !== 32'h1234) begin
      tests_failed++;
      $display("FAIL kmode_cdv: kmode=%b cdv=%h, required 0/1234", kmode, cdv);
    end
    cwe = 1; ctgt = 9; cwrite_data = 32'hCAFE_F00D; cs = 9;
    tick();
    cwe = 0;
    tests_run++;
    if (cd !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL cr_bypass: cd=%h, required cafef00d", cd);
    end
    cr_write(5'd20, 32'hABCD);
    cs = 20; tick();
    tests_run++;
    if (cd !== 32'd0) begin
      tests_failed++;
      $display("FAIL cr20_read: cd=%h, required 0", cd);
    end
    stall = 1; cs = 9; tick();
    stall = 0;
    tests_run++;
    if (cd !== 32'd0) begin
      tests_failed++;
      $display("FAIL cd_stall_hold: cd=%h, required 0", cd);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_dual_write();
    test_exception();
    test_interrupts();
    test_cr_misc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
